// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the 5-stage MIPS core: per-stage enables/flushes from
// load-use, branch/jump, data-memory wait and halt/drain/resume.
//
// state   | meaning
// RUN     | normal issue; hazards resolved by priority stall/flush
// MEMWAIT | data memory busy; whole pipe frozen, wait_cnt running
// DRAIN   | fetch stopped, bubbles pushed until ID..WB empty
// HALTED  | pipe empty; only leaves on resume
module hazard_sequencer #(
   parameter int CNT_W     = 16,
   parameter int MAX_WAIT  = 255,
   parameter int DRAIN_CYC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_jump,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int DRN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_MEMWAIT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_HALTED  = 2'd3;

   logic [1:0]        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [DRN_W-1:0]  drain_cnt;
   logic              halt_pend;
   logic              rt_src, load_use, memwait, advance, drain_entry;

   assign rt_src   = (id_opcode == 6'b000000) | (id_opcode == 6'b101011) |
                     (id_opcode == 6'b000101);
   assign load_use = ex_memread & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (rt_src & (ex_rt == id_rt)));
   assign memwait  = dmem_req & ~dmem_ready;
   assign advance  = ~memwait & ~load_use;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      if (reset) begin
         pc_en       = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (state == S_HALTED) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else begin
         if (memwait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
         end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (id_jump) begin
            ifid_flush = 1'b1;
         end
         // Draining still lets a taken branch load its target so resume restarts correctly.
         if (state == S_DRAIN) begin
            if (memwait | ~ex_branch_taken)
               pc_en = 1'b0;
            if (~memwait & (ex_branch_taken | ~load_use))
               ifid_flush = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         S_RUN: begin
            if (memwait) begin
               state_nxt = S_MEMWAIT;
               wait_nxt  = WAIT_W'(1);
            end else if (halt_req) begin
               state_nxt = S_DRAIN;
            end
         end
         S_MEMWAIT: begin
            if (~memwait) begin
               state_nxt = (halt_pend | halt_req) ? S_DRAIN : S_RUN;
               wait_nxt  = '0;
            end else if (wait_cnt != '1) begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         S_DRAIN: begin
            if (advance && (drain_cnt == '0))
               state_nxt = S_HALTED;
         end
         default: begin
            if (resume)
               state_nxt = S_RUN;
         end
      endcase
   end

   assign drain_entry = (state_nxt == S_DRAIN) && (state != S_DRAIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_RUN;
         wait_cnt  <= '0;
         drain_cnt <= '0;
         halt_pend <= 1'b0;
         halted    <= 1'b0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         halted   <= (state_nxt == S_HALTED);
         if (wait_nxt == WAIT_W'(MAX_WAIT))
            mem_err <= 1'b1;
         if (drain_entry)
            halt_pend <= 1'b0;
         else if (((state == S_RUN) || (state == S_MEMWAIT)) && memwait && halt_req)
            halt_pend <= 1'b1;
         // drain_cnt is a down-counter; terminal count 0 on an advancing cycle ends the drain.
         if (drain_entry)
            drain_cnt <= DRN_W'(DRAIN_CYC - 1);
         else if ((state == S_DRAIN) && advance && (drain_cnt != '0))
            drain_cnt <= drain_cnt - DRN_W'(1);
         if (((state == S_RUN) || (state == S_MEMWAIT)) && ~pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: each row drives one cycle of inputs and
// queues the expected control vector plus the registered status after the edge.
module tb_hazard_sequencer;

   logic       clk, reset;
   logic [5:0] id_opcode;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_jump, ex_memread, ex_branch_taken, dmem_req, dmem_ready, halt_req, resume;
   logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush;
   logic       halted, mem_err;
   logic [3:0] stall_cnt;
   logic [6:0] ctl_obs;

   hazard_sequencer #(.CNT_W(4), .MAX_WAIT(4), .DRAIN_CYC(4)) dut (
      .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .id_jump(id_jump), .ex_memread(ex_memread), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .halt_req(halt_req), .resume(resume), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .memwb_flush(memwb_flush), .halted(halted),
      .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   assign ctl_obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic rst; logic [5:0] op; logic [4:0] rs; logic [4:0] rt; logic jmp; logic mr;
      logic [4:0] exrt; logic br; logic req; logic rdy; logic hreq; logic res;
   } stim_t;
   typedef struct packed { logic [6:0] ctl; logic h; logic e; logic [3:0] s; } exp_t;

   // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
   localparam logic [6:0] C_DEF = 7'b1111000;
   localparam logic [6:0] C_MW  = 7'b0000001;
   localparam logic [6:0] C_BR  = 7'b1111110;
   localparam logic [6:0] C_LU  = 7'b0011010;
   localparam logic [6:0] C_JMP = 7'b1111100;
   localparam logic [6:0] C_RST = 7'b0111111;
   localparam logic [6:0] C_HLT = 7'b0011010;
   localparam logic [6:0] C_DRN = 7'b0111100;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '0; s.op = 6'b001000; s.rs = 5'd1; s.rt = 5'd2;
      return s;
   endfunction

   function automatic stim_t lu();
      stim_t s;
      s = idle(); s.op = 6'b000000; s.rs = 5'd8; s.rt = 5'd3; s.mr = 1'b1; s.exrt = 5'd8;
      return s;
   endfunction

   function automatic stim_t mw();
      stim_t s;
      s = idle(); s.req = 1'b1;
      return s;
   endfunction

   function automatic exp_t x(logic [6:0] c, logic h, logic e, logic [3:0] s);
      exp_t r;
      r.ctl = c; r.h = h; r.e = e; r.s = s;
      return r;
   endfunction

   task automatic drive(input stim_t s);
      reset = s.rst; id_opcode = s.op; id_rs = s.rs; id_rt = s.rt; id_jump = s.jmp;
      ex_memread = s.mr; ex_rt = s.exrt; ex_branch_taken = s.br; dmem_req = s.req;
      dmem_ready = s.rdy; halt_req = s.hreq; resume = s.res;
   endtask

   task automatic test_reset();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      t = mw(); t.rst = 1'b1; t.br = 1'b1; si.push_back(t); se.push_back(x(C_RST, 0, 0, 0));
      si.push_back(idle()); se.push_back(x(C_DEF, 0, 0, 0));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL reset[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL reset[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_load_use();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      si.push_back(lu()); se.push_back(x(C_LU, 0, 0, 1));
      si.push_back(idle()); se.push_back(x(C_DEF, 0, 0, 1));
      t = lu(); t.rs = 5'd3; t.rt = 5'd8; si.push_back(t); se.push_back(x(C_LU, 0, 0, 2));
      t = lu(); t.op = 6'b101011; t.rs = 5'd1; t.rt = 5'd8; si.push_back(t); se.push_back(x(C_LU, 0, 0, 3));
      t = lu(); t.op = 6'b000101; t.rs = 5'd1; t.rt = 5'd8; si.push_back(t); se.push_back(x(C_LU, 0, 0, 4));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL load_use[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL load_use[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_no_stall();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      t = lu(); t.exrt = 5'd0; t.rs = 5'd0; t.rt = 5'd0; si.push_back(t); se.push_back(x(C_DEF, 0, 0, 4));
      t = lu(); t.op = 6'b001110; t.rs = 5'd1; t.rt = 5'd8; si.push_back(t); se.push_back(x(C_DEF, 0, 0, 4));
      t = lu(); t.mr = 1'b0; si.push_back(t); se.push_back(x(C_DEF, 0, 0, 4));
      t = idle(); t.jmp = 1'b1; si.push_back(t); se.push_back(x(C_JMP, 0, 0, 4));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL no_stall[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL no_stall[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_branch();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      t = lu(); t.br = 1'b1; si.push_back(t); se.push_back(x(C_BR, 0, 0, 4));
      t = idle(); t.br = 1'b1; t.jmp = 1'b1; si.push_back(t); se.push_back(x(C_BR, 0, 0, 4));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL branch[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL branch[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_memwait();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      t = mw(); t.br = 1'b1; si.push_back(t); se.push_back(x(C_MW, 0, 0, 5));
      si.push_back(mw()); se.push_back(x(C_MW, 0, 0, 6));
      si.push_back(mw()); se.push_back(x(C_MW, 0, 0, 7));
      t = mw(); t.rdy = 1'b1; si.push_back(t); se.push_back(x(C_DEF, 0, 0, 7));
      si.push_back(idle()); se.push_back(x(C_DEF, 0, 0, 7));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL memwait[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL memwait[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_mem_err();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      si.push_back(mw()); se.push_back(x(C_MW, 0, 0, 8));
      si.push_back(mw()); se.push_back(x(C_MW, 0, 0, 9));
      si.push_back(mw()); se.push_back(x(C_MW, 0, 0, 10));
      si.push_back(mw()); se.push_back(x(C_MW, 0, 1, 11));
      si.push_back(mw()); se.push_back(x(C_MW, 0, 1, 12));
      t = mw(); t.rdy = 1'b1; si.push_back(t); se.push_back(x(C_DEF, 0, 1, 12));
      si.push_back(idle()); se.push_back(x(C_DEF, 0, 1, 12));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL mem_err[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL mem_err[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_drain();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      t = idle(); t.hreq = 1'b1; si.push_back(t); se.push_back(x(C_DEF, 0, 1, 12));
      si.push_back(idle()); se.push_back(x(C_DRN, 0, 1, 12));
      si.push_back(lu()); se.push_back(x(C_LU, 0, 1, 12));
      si.push_back(idle()); se.push_back(x(C_DRN, 0, 1, 12));
      t = idle(); t.br = 1'b1; si.push_back(t); se.push_back(x(C_BR, 0, 1, 12));
      si.push_back(mw()); se.push_back(x(C_MW, 0, 1, 12));
      si.push_back(idle()); se.push_back(x(C_DRN, 1, 1, 12));
      t = mw(); t.hreq = 1'b1; si.push_back(t); se.push_back(x(C_HLT, 1, 1, 12));
      t = idle(); t.res = 1'b1; si.push_back(t); se.push_back(x(C_HLT, 0, 1, 12));
      t = idle(); t.res = 1'b1; si.push_back(t); se.push_back(x(C_DEF, 0, 1, 12));
      si.push_back(lu()); se.push_back(x(C_LU, 0, 1, 13));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL drain[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL drain[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_halt_pend();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      t = mw(); t.hreq = 1'b1; si.push_back(t); se.push_back(x(C_MW, 0, 1, 14));
      t = mw(); t.rdy = 1'b1; si.push_back(t); se.push_back(x(C_DEF, 0, 1, 14));
      si.push_back(idle()); se.push_back(x(C_DRN, 0, 1, 14));
      si.push_back(idle()); se.push_back(x(C_DRN, 0, 1, 14));
      si.push_back(idle()); se.push_back(x(C_DRN, 0, 1, 14));
      si.push_back(idle()); se.push_back(x(C_DRN, 1, 1, 14));
      t = idle(); t.res = 1'b1; si.push_back(t); se.push_back(x(C_HLT, 0, 1, 14));
      si.push_back(idle()); se.push_back(x(C_DEF, 0, 1, 14));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL halt_pend[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL halt_pend[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_stall_sat();
      stim_t si[$]; exp_t se[$]; exp_t e;
      si.push_back(lu()); se.push_back(x(C_LU, 0, 1, 15));
      si.push_back(lu()); se.push_back(x(C_LU, 0, 1, 15));
      si.push_back(lu()); se.push_back(x(C_LU, 0, 1, 15));
      si.push_back(lu()); se.push_back(x(C_LU, 0, 1, 15));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL stall_sat[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL stall_sat[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   task automatic test_reset_mid();
      stim_t si[$]; exp_t se[$]; exp_t e; stim_t t;
      si.push_back(mw()); se.push_back(x(C_MW, 0, 1, 15));
      t = mw(); t.rst = 1'b1; si.push_back(t); se.push_back(x(C_RST, 0, 0, 0));
      si.push_back(idle()); se.push_back(x(C_DEF, 0, 0, 0));
      t = idle(); t.hreq = 1'b1; si.push_back(t); se.push_back(x(C_DEF, 0, 0, 0));
      si.push_back(idle()); se.push_back(x(C_DRN, 0, 0, 0));
      t = idle(); t.rst = 1'b1; si.push_back(t); se.push_back(x(C_RST, 0, 0, 0));
      si.push_back(idle()); se.push_back(x(C_DEF, 0, 0, 0));
      si.push_back(lu()); se.push_back(x(C_LU, 0, 0, 1));
      foreach (si[i]) begin
         @(negedge clk); drive(si[i]); sb.push_back(se[i]);
         #4; e = sb.pop_front();
         checks++;
         if (ctl_obs !== e.ctl) begin failures++; $display("FAIL reset_mid[%0d] ctl got=%b exp=%b", i, ctl_obs, e.ctl); end
         @(posedge clk); #1;
         checks++;
         if ({halted, mem_err, stall_cnt} !== {e.h, e.e, e.s})
            begin failures++; $display("FAIL reset_mid[%0d] halted/err/stall got=%b/%b/%0d exp=%b/%b/%0d", i, halted, mem_err, stall_cnt, e.h, e.e, e.s); end
      end
   endtask

   initial begin
      stim_t s0;
      s0 = idle(); s0.rst = 1'b1;
      drive(s0);
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_memwait();
      test_mem_err();
      test_drain();
      test_halt_pend();
      test_stall_sat();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
